// File: rtl/sram_regfile_mover_pkg.sv
// Shared constants and FSM encoding for the SRAM <-> register-file block mover.
package sram_regfile_mover_pkg;

  localparam int ADDR_W     = 11;
  localparam int REG_AW     = 5;
  localparam int CNT_W      = 6;
  localparam int REGS       = 32;
  localparam int SRAM_WORDS = 2048;

  localparam logic [CNT_W-1:0] MAX_XFER = CNT_W'(REGS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_ADDR = 3'd1,
    ST_LD_WB   = 3'd2,
    ST_ST_WR   = 3'd3,
    ST_FIN     = 3'd4
  } state_t;

  // A transfer never moves more than one full register file.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > MAX_XFER) ? MAX_XFER : c;
  endfunction

endpackage

// File: rtl/sram_regfile_mover_if.sv
// Control, SRAM and register-file signals of the block mover in one bundle.
// Handshake: start is a request sampled only while the mover is idle (busy=0); there is no
// ready/backpressure, a start seen while busy is dropped, and done pulses once per accepted start.
interface sram_regfile_mover_if;
  import sram_regfile_mover_pkg::*;

  logic               start;
  logic               dir;
  logic [ADDR_W-1:0]  sram_base;
  logic [REG_AW-1:0]  reg_base;
  logic [CNT_W-1:0]   count;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  sram_adx;
  logic               sram_we_n;
  logic [15:0]        sram_wdata;
  logic [15:0]        sram_rdata;
  logic [REG_AW-1:0]  reg_rd_adx;
  logic [31:0]        reg_rd_data;
  logic               reg_wr_en;
  logic [REG_AW-1:0]  reg_wr_adx;
  logic [31:0]        reg_wr_data;
  state_t             dbg_state;

  modport master (
    output start, dir, sram_base, reg_base, count, sram_rdata, reg_rd_data,
    input  busy, done, sram_adx, sram_we_n, sram_wdata,
           reg_rd_adx, reg_wr_en, reg_wr_adx, reg_wr_data, dbg_state
  );

  modport slave (
    input  start, dir, sram_base, reg_base, count, sram_rdata, reg_rd_data,
    output busy, done, sram_adx, sram_we_n, sram_wdata,
           reg_rd_adx, reg_wr_en, reg_wr_adx, reg_wr_data, dbg_state
  );

endinterface

// File: rtl/sram_regfile_mover.sv
// Block-transfer sequencer: moves up to 32 words between SRAM and the register file.
// Loads take two cycles per word (address, then write-back of the registered SRAM data); stores take one.
module sram_regfile_mover
  import sram_regfile_mover_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  sram_regfile_mover_if.slave bus
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  sram_ptr_q, sram_ptr_d;
  logic [REG_AW-1:0]  reg_ptr_q, reg_ptr_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [CNT_W-1:0]   start_cnt;
  logic [15:0]        unused_rd_hi;

  assign start_cnt    = sat_count(bus.count);
  assign unused_rd_hi = bus.reg_rd_data[31:16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sram_ptr_q <= '0;
      reg_ptr_q  <= '0;
      remain_q   <= '0;
    end else begin
      state_q    <= state_d;
      sram_ptr_q <= sram_ptr_d;
      reg_ptr_q  <= reg_ptr_d;
      remain_q   <= remain_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sram_ptr_d = sram_ptr_q;
    reg_ptr_d  = reg_ptr_q;
    remain_d   = remain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sram_ptr_d = bus.sram_base;
          reg_ptr_d  = bus.reg_base;
          remain_d   = start_cnt;
          if (start_cnt == '0)  state_d = ST_FIN;
          else if (bus.dir)     state_d = ST_ST_WR;
          else                  state_d = ST_LD_ADDR;
        end
      end
      ST_LD_ADDR: state_d = ST_LD_WB;
      ST_LD_WB: begin
        // Pointers wrap naturally at their widths; no overflow is flagged.
        sram_ptr_d = sram_ptr_q + 1'b1;
        reg_ptr_d  = reg_ptr_q + 1'b1;
        remain_d   = remain_q - 1'b1;
        state_d    = (remain_q > CNT_W'(1)) ? ST_LD_ADDR : ST_FIN;
      end
      ST_ST_WR: begin
        sram_ptr_d = sram_ptr_q + 1'b1;
        reg_ptr_d  = reg_ptr_q + 1'b1;
        remain_d   = remain_q - 1'b1;
        state_d    = (remain_q > CNT_W'(1)) ? ST_ST_WR : ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.sram_adx    = '0;
    bus.sram_we_n   = 1'b1;
    bus.sram_wdata  = '0;
    bus.reg_rd_adx  = '0;
    bus.reg_wr_en   = 1'b0;
    bus.reg_wr_adx  = '0;
    bus.reg_wr_data = '0;
    bus.done        = 1'b0;
    unique case (state_q)
      ST_LD_ADDR: begin
        bus.sram_adx = sram_ptr_q;
      end
      ST_LD_WB: begin
        bus.reg_wr_en   = 1'b1;
        bus.reg_wr_adx  = reg_ptr_q;
        bus.reg_wr_data = {16'h0000, bus.sram_rdata};
      end
      ST_ST_WR: begin
        // Only the low half of each register fits the 16-bit SRAM word.
        bus.reg_rd_adx = reg_ptr_q;
        bus.sram_adx   = sram_ptr_q;
        bus.sram_we_n  = 1'b0;
        bus.sram_wdata = bus.reg_rd_data[15:0];
      end
      ST_FIN:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.dbg_state = state_q;

endmodule
